// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the execute-stage branch resolver.
package branch_resolver_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_rec_t;

  typedef enum logic {
    RUN,
    FLUSH
  } br_state_t;

endpackage

// File: rtl/branch_resolver_pred_queue.sv
// In-order FIFO of fetch-stage prediction records with synchronous clear.
module pred_queue
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      Clk,
  input  logic      Rst,
  input  logic      clr_i,
  input  logic      push_i,
  input  pred_rec_t push_rec_i,
  input  logic      pop_i,
  output pred_rec_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  pred_rec_t mem_q [DEPTH];
  ptr_t      wr_q, rd_q;
  cnt_t      cnt_q, cnt_d;
  logic      do_push, do_pop;

  assign full_o  = (cnt_q == cnt_t'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Push into a full queue only succeeds when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Record storage; contents are don't-care while not counted as valid.
  always_ff @(posedge Clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= push_rec_i;
  end

  // Pointers and count; power-of-two depth makes pointer overflow the wrap.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + ptr_t'(1);
      if (do_pop)  rd_q <= rd_q + ptr_t'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks queued predictions, redirects and trains.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_pred_taken,
  input  logic [31:0] f_pred_target,
  output logic        f_ready,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_branch,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count,
  output logic        seq_err
);

  localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

  br_state_t   state_q, state_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;

  pred_rec_t   q_head, head_eff, push_rec;
  logic        q_full, q_empty, q_push;
  logic        accept, act_taken, seq_bad, mispredict, upd_fire;
  logic [31:0] act_next;

  logic        redirect_valid_q, upd_valid_q, upd_taken_q, seq_err_q;
  logic [31:0] redirect_pc_q, upd_pc_q, upd_target_q;
  logic [31:0] branch_cnt_q, mis_cnt_q;

  assign f_ready = !q_full && (state_q == RUN);
  assign q_push  = f_valid && f_ready;

  assign push_rec.pc          = f_pc;
  assign push_rec.pred_taken  = f_pred_taken;
  assign push_rec.pred_target = f_pred_target;

  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .Clk        (Clk),
    .Rst        (Rst),
    .clr_i      (mispredict),
    .push_i     (q_push),
    .push_rec_i (push_rec),
    .pop_i      (accept),
    .head_o     (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty)
  );

  // Compare the queue head against the actual outcome of the resolving instruction.
  always_comb begin
    head_eff = q_head;
    if (q_empty) begin
      head_eff.pc          = e_pc;
      head_eff.pred_taken  = 1'b0;
      head_eff.pred_target = e_pc + PC_STEP;
    end
    accept     = (state_q == RUN) && e_valid;
    act_taken  = e_branch && e_taken;
    act_next   = act_taken ? e_target : (e_pc + PC_STEP);
    seq_bad    = accept && (head_eff.pc != e_pc);
    mispredict = accept && ((head_eff.pred_target != act_next) ||
                            (head_eff.pred_taken != act_taken) || seq_bad);
    upd_fire   = accept && (e_branch || head_eff.pred_taken);
  end

  // Next-state: a mispredict loads the flush down-counter.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = CW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= CW'(1)) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - CW'(1);
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Registered redirect, training pulse, saturating counters and sticky sequence error.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      upd_taken_q      <= 1'b0;
      branch_cnt_q     <= '0;
      mis_cnt_q        <= '0;
      seq_err_q        <= 1'b0;
    end else begin
      redirect_valid_q <= mispredict;
      if (mispredict) redirect_pc_q <= act_next;
      upd_valid_q <= upd_fire;
      if (upd_fire) begin
        upd_pc_q     <= e_pc;
        upd_target_q <= e_target;
        upd_taken_q  <= act_taken;
      end
      if (accept && e_branch && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
      if (seq_bad) seq_err_q <= 1'b1;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = (state_q == FLUSH);
  assign upd_valid        = upd_valid_q;
  assign upd_pc           = upd_pc_q;
  assign upd_target       = upd_target_q;
  assign upd_taken        = upd_taken_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mis_cnt_q;
  assign seq_err          = seq_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, table-driven bench for branch_resolver (DEPTH=4, FLUSH_CYCLES=2).
module tb_branch_resolver;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [31:0] f_pc = '0;
  logic        f_pred_taken = 1'b0;
  logic [31:0] f_pred_target = '0;
  logic        f_ready;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc = '0;
  logic        e_branch = 1'b0;
  logic        e_taken = 1'b0;
  logic [31:0] e_target = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        seq_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  branch_resolver #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .f_valid          (f_valid),
    .f_pc             (f_pc),
    .f_pred_taken     (f_pred_taken),
    .f_pred_target    (f_pred_target),
    .f_ready          (f_ready),
    .e_valid          (e_valid),
    .e_pc             (e_pc),
    .e_branch         (e_branch),
    .e_taken          (e_taken),
    .e_target         (e_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_taken        (upd_taken),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count),
    .seq_err          (seq_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] rpc;
    logic        upd;
    logic        updtk;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_rec(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    f_valid = 1'b1; f_pc = pc; f_pred_taken = pt; f_pred_target = ptgt;
    step();
    f_valid = 1'b0;
  endtask

  task automatic set_exec(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    e_valid = 1'b1; e_pc = pc; e_branch = br; e_taken = tk; e_target = tgt;
  endtask

  task automatic wait_flush();
    step();
    chk("flush_2nd_cycle", flush, 1);
    chk("redirect_pulse", redirect_valid, 0);
    chk("upd_pulse_fl", upd_valid, 0);
    step();
    chk("flush_end", flush, 0);
    chk("f_ready_after_flush", f_ready, 1);
  endtask

  logic [31:0] exp_br, exp_mis;

  initial begin
    //            pc            pt  ptgt          br  tk  tgt           mis rpc           upd tk
    vt[0] = '{32'h0000_0100, 1, 32'h0000_0200, 1, 1, 32'h0000_0200, 0, 32'h0,         1, 1};
    vt[1] = '{32'h0000_0104, 0, 32'h0000_0108, 1, 1, 32'h0000_0300, 1, 32'h0000_0300, 1, 1};
    vt[2] = '{32'h0000_0110, 1, 32'h0000_0400, 0, 0, 32'h0000_0400, 1, 32'h0000_0114, 1, 0};
    vt[3] = '{32'h0000_0130, 0, 32'h0000_0134, 1, 0, 32'h0000_0500, 0, 32'h0,         1, 0};
    vt[4] = '{32'h0000_0140, 0, 32'h0000_0144, 0, 0, 32'h0000_0000, 0, 32'h0,         0, 0};
    vt[5] = '{32'h0000_0150, 1, 32'h0000_0600, 1, 1, 32'h0000_0700, 1, 32'h0000_0700, 1, 1};
    vt[6] = '{32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 0, 32'h0000_0000, 0, 32'h0,         0, 0};
    exp_br  = 0;
    exp_mis = 0;

    // Reset state
    step();
    step();
    chk("rst_flush", flush, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mis_count", mispredict_count, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_f_ready", f_ready, 1);
    Rst = 1'b0;
    step();

    // Single push/resolve vectors
    for (int i = 0; i < 7; i++) begin
      push_rec(vt[i].pc, vt[i].pt, vt[i].ptgt);
      set_exec(vt[i].pc, vt[i].br, vt[i].tk, vt[i].tgt);
      if (vt[i].mis) begin
        // a push in the mispredict cycle must be dropped
        f_valid = 1'b1; f_pc = 32'hDEAD_0000; f_pred_taken = 1'b1; f_pred_target = 32'hDEAD_0004;
      end
      step();
      e_valid = 1'b0;
      if (vt[i].br) exp_br = exp_br + 1;
      if (vt[i].mis) exp_mis = exp_mis + 1;
      chk($sformatf("v%0d_redirect_valid", i), redirect_valid, vt[i].mis);
      chk($sformatf("v%0d_flush", i), flush, vt[i].mis);
      chk($sformatf("v%0d_upd_valid", i), upd_valid, vt[i].upd);
      if (vt[i].mis) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vt[i].rpc);
      if (vt[i].upd) begin
        chk($sformatf("v%0d_upd_pc", i), upd_pc, vt[i].pc);
        chk($sformatf("v%0d_upd_target", i), upd_target, vt[i].tgt);
        chk($sformatf("v%0d_upd_taken", i), upd_taken, vt[i].updtk);
      end
      chk($sformatf("v%0d_branch_count", i), branch_count, exp_br);
      chk($sformatf("v%0d_mis_count", i), mispredict_count, exp_mis);
      if (vt[i].mis) begin
        chk($sformatf("v%0d_f_ready_flush", i), f_ready, 0);
        wait_flush();
        f_valid = 1'b0;
      end else begin
        step();
        chk($sformatf("v%0d_upd_pulse", i), upd_valid, 0);
      end
      chk($sformatf("v%0d_seq_err", i), seq_err, 0);
    end

    // Fill queue, drop an overflow push, then keep order across pointer wrap
    for (int i = 0; i < 4; i++) push_rec(32'h0000_0200 + 32'(i * 4), 1'b0, 32'h0000_0204 + 32'(i * 4));
    chk("full_f_ready", f_ready, 0);
    push_rec(32'h0000_0900, 1'b0, 32'h0000_0904);
    set_exec(32'h0000_0200, 1'b0, 1'b0, 32'h0);
    step();
    chk("pop_f_ready", f_ready, 1);
    f_valid = 1'b1; f_pc = 32'h0000_0210; f_pred_taken = 1'b0; f_pred_target = 32'h0000_0214;
    set_exec(32'h0000_0204, 1'b0, 1'b0, 32'h0);
    step();
    f_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_exec(32'h0000_0208 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
      step();
      chk($sformatf("wrap%0d_redirect", i), redirect_valid, 0);
      chk($sformatf("wrap%0d_seq_err", i), seq_err, 0);
    end
    e_valid = 1'b0;
    step();
    chk("wrap_mis_count", mispredict_count, exp_mis);

    // Sequence error, execute ignored during flush, reset mid-flush
    push_rec(32'h0000_0120, 1'b0, 32'h0000_0124);
    set_exec(32'h0000_0124, 1'b0, 1'b0, 32'h0);
    step();
    exp_mis = exp_mis + 1;
    chk("seq_redirect_valid", redirect_valid, 1);
    chk("seq_redirect_pc", redirect_pc, 32'h0000_0128);
    chk("seq_err_set", seq_err, 1);
    chk("seq_flush", flush, 1);
    chk("seq_upd_valid", upd_valid, 0);
    chk("seq_mis_count", mispredict_count, exp_mis);
    set_exec(32'h0000_0999, 1'b1, 1'b1, 32'h0000_1234);
    step();
    e_valid = 1'b0;
    chk("fl_ignore_redirect", redirect_valid, 0);
    chk("fl_ignore_upd", upd_valid, 0);
    chk("fl_ignore_br_count", branch_count, exp_br);
    chk("fl_ignore_mis_count", mispredict_count, exp_mis);
    chk("seq_err_sticky", seq_err, 1);
    chk("fl_still_flush", flush, 1);
    Rst = 1'b1;
    #1;
    chk("midrst_flush", flush, 0);
    chk("midrst_seq_err", seq_err, 0);
    chk("midrst_redirect_pc", redirect_pc, 0);
    chk("midrst_branch_count", branch_count, 0);
    chk("midrst_mis_count", mispredict_count, 0);
    chk("midrst_upd_pc", upd_pc, 0);
    chk("midrst_f_ready", f_ready, 1);
    #1;
    Rst = 1'b0;
    step();
    chk("postrst_f_ready", f_ready, 1);
    chk("postrst_flush", flush, 0);

    // Counter saturation
    force dut.branch_cnt_q = 32'hFFFF_FFFE;
    force dut.mis_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mis_cnt_q;
    for (int i = 0; i < 2; i++) begin
      push_rec(32'h0000_0300, 1'b0, 32'h0000_0304);
      set_exec(32'h0000_0300, 1'b1, 1'b1, 32'h0000_0800);
      step();
      e_valid = 1'b0;
      chk($sformatf("sat%0d_redirect", i), redirect_valid, 1);
      chk($sformatf("sat%0d_branch_count", i), branch_count, 32'hFFFF_FFFF);
      chk($sformatf("sat%0d_mis_count", i), mispredict_count, 32'hFFFF_FFFF);
      wait_flush();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-stage counterpart to the fetch-stage BTB/BHT predictor.
- Queues every fetch-stage prediction in order and compares each one with the actual outcome when its instruction reaches execute.
- On a misprediction it drives the redirect and flush signals to the hazard unit.
- For every resolved branch it drives the training/update port back to the BTB/BHT.

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, ≥2)
FLUSH_CYCLES, 2, cycles flush held after a mispredict (≥1)

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  reset
f_valid  in  1  fetch pushes a prediction record this cycle
f_pc  in  32  PC of fetched instruction
f_pred_taken  in  1  predictor said taken
f_pred_target  in  32  predicted next PC (f_pc+4 when not taken)
f_ready  out  1  queue can accept a push
e_valid  in  1  instruction in execute resolves this cycle
e_pc  in  32  PC of instruction in execute
e_branch  in  1  instruction is a branch
e_taken  in  1  branch actually taken
e_target  in  32  computed branch target
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  32  correct next PC
flush  out  1  kill fetch/decode stages
upd_valid  out  1  one-cycle pulse: train BTB/BHT
upd_pc  out  32  PC to train
upd_target  out  32  taken target to store
upd_taken  out  1  actual outcome
branch_count  out  32  resolved branches, saturating
mispredict_count  out  32  mispredicts, saturating
seq_err  out  1  sticky: queue head PC ≠ e_pc

Behaviour:
- Reset Rst is asynchronous and active-high. All outputs and counters reset to 0, the queue is emptied, and the FSM goes to RUN.
- Queue: in-order FIFO of {pc, pred_taken, pred_target}.
  - Push when f_valid && f_ready.
  - Pop when e_valid is accepted.
  - f_ready = !full && state==RUN.
  - Simultaneous push and pop when full is allowed and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Resolve (state==RUN, e_valid=1) in cycle N:
  - If the queue is empty, the head is treated as {e_pc, 0, e_pc+4}.
  - If head.pc ≠ e_pc, seq_err is set (sticky until Rst) and the instruction is forced to mispredict.
  - actual_next = (e_branch && e_taken) ? e_target : e_pc+4, computed modulo 2^32.
  - mispredict = (head.pred_target ≠ actual_next) || (head.pred_taken ≠ (e_branch && e_taken)) || seq_err condition.
  - upd_* is registered and valid in cycle N+1 for 1 cycle when e_branch=1, or when head.pred_taken=1 and e_branch=0 (trains alias with upd_taken=0). Values: upd_pc=e_pc, upd_target=e_target, upd_taken=e_branch&&e_taken.
  - branch_count increments when e_branch=1. mispredict_count increments on mispredict. Both saturate at 0xFFFFFFFF.
- On mispredict:
  - In cycle N+1, redirect_valid=1 and redirect_pc=actual_next. redirect_pc otherwise holds its last value.
  - The whole queue is cleared at the N edge, discarding younger predictions.
  - A push in cycle N is dropped.
- FSM:
  - RUN → FLUSH on mispredict.
  - FLUSH holds flush=1 for exactly FLUSH_CYCLES cycles, starting N+1, via a down-counter, then returns to RUN.
  - In FLUSH: e_valid is ignored (no pop, no update, no count) and f_valid is ignored.
  - flush=0 in RUN.
- Rst asserted mid-FLUSH aborts immediately to RUN with the queue empty.
- upd_valid and redirect_valid are never asserted for more than 1 consecutive cycle from the same resolve.

Decomposition:
- Shared package holds:
  - typedef pred_rec_t {pc[31:0], pred_taken, pred_target[31:0]}
  - FSM state enum {RUN, FLUSH}
  - constant PC_STEP = 4
- One natural sub-module: pred_queue (parameterised FIFO of pred_rec_t with synchronous clear, full/empty, async Rst).
- Compare logic, FSM and counters stay in branch_resolver.

Test Plan:
1. Push {0x100,1,0x200}; resolve e_pc=0x100, branch, taken, target 0x200 → no flush/redirect; N+1 upd_valid=1, upd_pc=0x100, upd_target=0x200, upd_taken=1; branch_count=1, mispredict_count=0.
2. Push {0x104,0,0x108}; resolve branch taken target 0x300 → N+1 redirect_valid=1, redirect_pc=0x300; flush high 2 cycles; queue empty; f_ready low during flush; mispredict_count=1.
3. Push {0x110,1,0x400}; resolve e_branch=0 → redirect_pc=0x114; upd_valid=1 with upd_taken=0; branch_count unchanged.
4. Push 4 records with no pop → f_ready=0. Fifth f_valid is dropped. Simultaneous push+pop while full keeps count=4 and the order is preserved across wrap.
5. Push {0x120,…}; resolve e_pc=0x124 → seq_err=1 (stays 1), mispredict path taken. Assert Rst during the following flush → all outputs 0, seq_err 0, f_ready=1 next cycle.
6. Preload both counters near 0xFFFFFFFF via repeated mispredicts (or force) → both counters hold at 0xFFFFFFFF without wrap.
